// File: rtl/id_stage_reg.sv
// ID stage: register file with writeback bypass, immediate decode and the
// ID/EX pipeline register with stall, bubble and flush handling.
module id_stage_reg #(
  parameter int XLEN           = 32,
  parameter int NUM_REGS       = 32,
  parameter int REG_AW         = $clog2(NUM_REGS),
  parameter bit LONG_IMM_UPPER = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_id_valid,
  output logic              if_id_ready,
  input  logic [31:0]       if_id_ir,
  input  logic [XLEN-1:0]   if_id_npc,
  input  logic              hazard,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              id_ex_valid,
  input  logic              id_ex_ready,
  output logic [XLEN-1:0]   id_ex_a,
  output logic [XLEN-1:0]   id_ex_b,
  output logic [XLEN-1:0]   id_ex_npc,
  output logic [31:0]       id_ex_ir,
  output logic [XLEN-1:0]   id_ex_imm
);

  logic [XLEN-1:0]   regs [NUM_REGS];
  logic [REG_AW-1:0] rs1, rs2, held_rs1, held_rs2;
  logic [XLEN-1:0]   op_a, op_b;
  logic [XLEN-1:0]   imm_short, imm_long, imm_next;
  logic signed [11:0] imm12;
  logic signed [19:0] imm20;
  logic signed [31:0] imm_upper32;
  logic              free;
  logic              wb_hit;
  logic              unused_ir;

  assign rs1      = if_id_ir[15 +: REG_AW];
  assign rs2      = if_id_ir[20 +: REG_AW];
  assign held_rs1 = id_ex_ir[15 +: REG_AW];
  assign held_rs2 = id_ex_ir[20 +: REG_AW];
  assign unused_ir = ^{if_id_ir[19:15], if_id_ir[11:3], if_id_ir[1:0]};

  // Signed casts give the sign extension to XLEN without zero-width replications.
  assign imm12       = if_id_ir[31:20];
  assign imm20       = if_id_ir[31:12];
  assign imm_upper32 = {if_id_ir[31:12], 12'h000};
  assign imm_short   = XLEN'(imm12);
  assign imm_long    = LONG_IMM_UPPER ? XLEN'(imm_upper32) : XLEN'(imm20);
  assign imm_next    = if_id_ir[2] ? imm_long : imm_short;

  assign wb_hit = wb_we && (wb_rd != '0);
  assign free   = !id_ex_valid || id_ex_ready;
  assign if_id_ready = reset_n && free && !hazard && !flush;

  // A same-cycle writeback wins over the array so the capture never sees stale data.
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (rs1 != '0) begin
      if (wb_we && wb_rd == rs1) op_a = wb_data;
      else                       op_a = regs[rs1];
    end
    if (rs2 != '0) begin
      if (wb_we && wb_rd == rs2) op_b = wb_data;
      else                       op_b = regs[rs2];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // A stalled instruction keeps tracking writebacks to its sources.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_ex_valid <= 1'b0;
      id_ex_a     <= '0;
      id_ex_b     <= '0;
      id_ex_npc   <= '0;
      id_ex_ir    <= '0;
      id_ex_imm   <= '0;
    end else if (flush) begin
      id_ex_valid <= 1'b0;
      id_ex_ir    <= '0;
      id_ex_imm   <= '0;
    end else if (!free) begin
      if (wb_hit && wb_rd == held_rs1) id_ex_a <= wb_data;
      if (wb_hit && wb_rd == held_rs2) id_ex_b <= wb_data;
    end else if (hazard) begin
      id_ex_valid <= 1'b0;
      id_ex_ir    <= '0;
      id_ex_imm   <= '0;
    end else if (if_id_valid) begin
      id_ex_valid <= 1'b1;
      id_ex_a     <= op_a;
      id_ex_b     <= op_b;
      id_ex_npc   <= if_id_npc;
      id_ex_ir    <= if_id_ir;
      id_ex_imm   <= imm_next;
    end else begin
      id_ex_valid <= 1'b0;
      id_ex_ir    <= '0;
      id_ex_imm   <= '0;
    end
  end

endmodule

// File: doc/id_stage_reg.md
Name: id_stage_reg

Overview:
- Parametrised instruction-decode pipeline register, sitting between the IF/ID register and the EX stage.
- Contains the architectural register file with writeback bypass and generates sign-extended short or long immediates.
- Captures operands, NPC, IR and immediate into the ID/EX register under a valid/ready handshake.
- Distinguishes downstream stall (hold), hazard (bubble) and flush (kill); the earlier decode stage could only recirculate NOPs.

Parameters:
- XLEN, 32, datapath width of operands, NPC, IR and immediate; must be ≥ 32 (IR is always 32 bits; NPC/IR zero-extended to XLEN).
- NUM_REGS, 32, register file depth; power of two, ≤ 32.
- REG_AW, $clog2(NUM_REGS), register index width; rs1/rs2/rd index fields use their low REG_AW bits.
- LONG_IMM_UPPER, 0, 0: long immediate is sign-extended ir[31:12]; 1: long immediate is ir[31:12] placed at bits [31:12], low 12 bits zero, sign-extended above bit 31.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- if_id_valid  in  1  IF/ID holds a valid instruction
- if_id_ready  out  1  stage accepts the instruction this cycle
- if_id_ir  in  32  instruction
- if_id_npc  in  XLEN  next PC
- hazard  in  1  load-use hazard: insert bubble, hold IF
- flush  in  1  branch/exception kill of the ID/EX contents
- wb_we  in  1  register file write enable
- wb_rd  in  REG_AW  write index
- wb_data  in  XLEN  write data
- id_ex_valid  out  1  ID/EX holds a valid instruction
- id_ex_ready  in  1  EX accepts ID/EX this cycle
- id_ex_a  out  XLEN  rs1 operand
- id_ex_b  out  XLEN  rs2 operand
- id_ex_npc  out  XLEN  captured NPC
- id_ex_ir  out  32  captured IR; 0 when bubble
- id_ex_imm  out  XLEN  decoded immediate

Behaviour:
- Decode fields: rs1 = ir[19:15], rs2 = ir[24:20]. long_imm = ir[2]. Short imm = sign-extend ir[31:20]. Long imm = sign-extend ir[31:12], or upper form per LONG_IMM_UPPER.
- Register file: NUM_REGS x XLEN flops. Write on posedge when wb_we && wb_rd != 0. Register 0 always reads 0. Reads are combinational.
- Bypass: if wb_we && wb_rd == rs && rs != 0 in the capture cycle, the operand is wb_data, not the stale array value.
- free = !id_ex_valid || id_ex_ready.
- if_id_ready = free && !hazard && !flush (combinational).
- Priority per cycle:
  - flush: id_ex_valid <= 0, id_ex_ir <= 0, id_ex_imm <= 0; nothing is captured.
  - else if !free: hold all outputs (stall). Hazard is ignored while the stage is stalled; the instruction is never dropped.
  - else if hazard: bubble. id_ex_valid <= 0, ir/imm <= 0. A, B and NPC keep their old values.
  - else if if_id_valid: capture; id_ex_valid <= 1, latency 1 cycle.
  - else: id_ex_valid <= 0, ir/imm <= 0.
- Hold refresh: while stalled with id_ex_valid = 1, a wb write matching the held instruction's rs1 (or rs2), with a nonzero index, updates id_ex_a (or id_ex_b) with wb_data. This prevents stale operands.
- Simultaneous write and capture to the same index: capture sees the new value via bypass; the array updates the same edge.
- Reset (reset_n low, any time, asynchronous):
  - all id_ex_* outputs = 0;
  - register file cleared to 0;
  - if_id_ready = 0 while reset is asserted;
  - any in-flight instruction is discarded.
- No combinational path from if_id_valid to if_id_ready.

Test Plan:
- Reset mid-stream: assert reset_n low with id_ex_valid = 1 → all outputs 0 immediately, without waiting for a clock edge; after release, the first captured instruction has A = B = 0.
- Imm modes: ir = 0xFFF0_0013 (ir[2] = 0) → imm = 0xFFFF_FFFF. ir = 0x8000_0037 (ir[2] = 1):
  - LONG_IMM_UPPER = 0 → imm = 0xFFF8_0000;
  - LONG_IMM_UPPER = 1 → imm = 0x8000_0000.
- Bypass: write x5 = 0x1234 in the same cycle an instruction with rs1 = 5 is captured → id_ex_a = 0x1234. rs1 = 0 with wb_rd = 0 → id_ex_a = 0.
- Stall and refresh: id_ex_ready = 0 for 3 cycles; write the held rs2 → outputs otherwise stable, id_ex_b updated, if_id_ready = 0. Release → same instruction consumed once.
- Hazard vs flush: hazard one cycle → id_ex_valid = 0, ir = 0, if_id_ready = 0, next instruction captured the following cycle. Flush together with hazard and a valid input → bubble, input not accepted.
- NUM_REGS = 16, XLEN = 64 build: write x15 and read it back → 64-bit value returned; ir = 0x8000_0037 with LONG_IMM_UPPER = 0 → imm = 0xFFFF_FFFF_FFF8_0000.
